imem_loadable: RTL
==================

# imem_loadable

Parametrised, loadable instruction memory for the fetch stage of the core. After reset it clears its storage, accepts a streamed program image over a valid/ready load port, and then serves registered instruction reads to fetch. Word width, address width and depth are generic. An optional per-word parity check is compiled in by macro.

## Interface
Parameters:
- ADDR_W, 12, address width.
- INSTR_W, 19, instruction word width.
- DEPTH, 1<<ADDR_W, number of words (≤ 2**ADDR_W).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  load word present.
- load_data  in  INSTR_W  program word.
- load_last  in  1  marks the final word of the image.
- load_ready  out  1  memory accepts a load word this cycle.
- ready  out  1  image loaded; reads serviced.
- rd_en  in  1  read request.
- address  in  ADDR_W  read word address.
- instruction  out  INSTR_W  read data.
- instr_valid  out  1  instruction holds fresh data this cycle.
- addr_err  out  1  read address ≥ DEPTH (pulse, aligned with instr_valid).
- parity_err  out  1  present only with IMEM_PARITY_EN.

## Operation
- FSM states: CLEAR, LOAD, RUN.
- CLEAR: a counter walks 0..DEPTH-1 and writes all-zero (NOP) to one word per cycle. After writing DEPTH-1 it goes to LOAD with the pointer at 0.
- LOAD: load_ready=1. On load_valid&&load_ready, write load_data to mem[ptr] and increment ptr. Go to RUN on a handshake with load_last=1, or on the handshake at ptr=DEPTH-1. Further load words are never accepted, and overflow is impossible. Unloaded words stay zero.
- RUN: ready=1, load_ready=0; load_valid is ignored.
- Read in RUN with rd_en=1:
  - address < DEPTH: instruction=mem[address].
  - address ≥ DEPTH: instruction=0 and addr_err=1.
- rd_en while not in RUN is ignored: instr_valid stays 0.
- With rd_en=0, instruction holds its last value and instr_valid=0.
- rst in any state (including mid-load or mid-clear) returns the block to CLEAR, and the whole memory is re-zeroed.

## Timing
- Reset values: instruction=0, instr_valid=0, addr_err=0, parity_err=0, load_ready=0, ready=0.
- First cycle after rst deasserts: CLEAR, counter 0. load_ready first goes high DEPTH cycles later.
- Load throughput: one word per cycle. load_ready drops the cycle after the terminating handshake, and ready rises in that same cycle.
- Read latency is 1 cycle: rd_en/address sampled at edge N, instruction/instr_valid/addr_err valid after edge N, for one cycle per request. Back-to-back reads are allowed every cycle.
- A read issued in the first RUN cycle returns the word loaded on the final handshake. Write-before-read ordering is guaranteed.

## Configuration
- IMEM_PARITY_EN defined:
  - Each stored word carries an extra even-parity bit, computed on the CLEAR and LOAD writes.
  - Each read recomputes parity and pulses parity_err with instr_valid on a mismatch. Data is still returned.
  - addr_err reads report parity_err=0.
- IMEM_PARITY_EN undefined: storage is INSTR_W wide, the parity_err port does not exist, and there is no parity logic.

## Structure
- Package imem_pkg holds:
  - typedef enum imem_state_t {IMEM_CLEAR, IMEM_LOAD, IMEM_RUN}.
  - Default-width localparams IMEM_ADDR_W=12 and IMEM_INSTR_W=19.
  - Function imem_parity() (used only with the macro).
- Sub-module imem_load_ctrl contains the FSM, the clear/load pointer, and load_ready/ready. It drives the write enable, write address and write data into the storage array, which lives in the top.

## Test plan
Bench uses DEPTH=16, ADDR_W=5, INSTR_W=19.
- Reset, then stream 3 words 19'h0400A, 19'h1234F, 19'h7FFFF with load_last on the 3rd. Expected: load_ready rises 16 cycles after reset, ready rises the cycle after the 3rd handshake, and reads of addresses 0/1/2 return those words with 1-cycle latency.
- Reads of addresses 3 and 15 after that load -> 0. Read of address 20 -> instruction=0, addr_err=1.
- Stream 16 words without load_last -> RUN after the 16th handshake. A 17th load_valid is not accepted (load_ready=0).
- Assert rst after 2 load words, then reload with 1 word 19'h00001 -> address 0=1, address 1=0 (re-cleared).
- rd_en pulses before ready -> instr_valid stays 0. Continuous rd_en in RUN over addresses 0..15 -> instr_valid high every cycle with matching data.
- IMEM_PARITY_EN: flip one stored data bit by hierarchical deposit, then read it -> parity_err=1 with instr_valid. A clean word reads with parity_err=0.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared types, default widths and helpers for the loadable
// instruction memory. The parity helper is only referenced when the design
// is built with IMEM_PARITY_EN defined.
package imem_pkg;

  localparam int IMEM_ADDR_W       = 12;
  localparam int IMEM_INSTR_W      = 19;
  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves their parity unchanged.
  localparam int IMEM_PARITY_MAX_W = 64;

  typedef enum logic [1:0] {
    IMEM_CLEAR,
    IMEM_LOAD,
    IMEM_RUN
  } imem_state_t;

  // Even-parity bit: word plus this bit always holds an even number of ones.
  function automatic logic imem_parity(input logic [IMEM_PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: CLEAR/LOAD/RUN sequencer for the instruction memory.
// Walks the storage writing zeros after reset, then accepts the streamed
// program image one word per cycle and drives the storage write port.
// Parity (IMEM_PARITY_EN) is handled by the top; this block is unaffected.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int PTR_W   = 12,
  parameter int INSTR_W = 19,
  parameter int DEPTH   = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid_i,
  input  logic [INSTR_W-1:0] load_data_i,
  input  logic               load_last_i,
  output logic               load_ready_o,
  output logic               ready_o,
  output logic               we_o,
  output logic [PTR_W-1:0]   waddr_o,
  output logic [INSTR_W-1:0] wdata_o
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  imem_state_t      state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // State and clear/load pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IMEM_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: clear walks every word, load stops on last flag or full memory.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IMEM_CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = IMEM_LOAD;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      IMEM_LOAD: begin
        if (load_valid_i) begin
          ptr_d = ptr_q + PTR_W'(1);
          if (load_last_i || (ptr_q == LAST_PTR)) begin
            state_d = IMEM_RUN;
          end
        end
      end
      IMEM_RUN: begin
      end
      default: begin
        state_d = IMEM_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Outputs: write port control and handshake/status flags per state.
  always_comb begin
    load_ready_o = 1'b0;
    ready_o      = 1'b0;
    we_o         = 1'b0;
    waddr_o      = ptr_q;
    wdata_o      = '0;
    case (state_q)
      IMEM_CLEAR: begin
        we_o = 1'b1;
      end
      IMEM_LOAD: begin
        load_ready_o = 1'b1;
        we_o         = load_valid_i;
        wdata_o      = load_data_i;
      end
      IMEM_RUN: begin
        ready_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/imem_loadable.sv
// imem_loadable: loadable instruction memory for the fetch stage.
// Storage is zeroed after reset, filled from the load port, then serves
// registered reads with one cycle of latency. Define IMEM_PARITY_EN to add a
// per-word even-parity bit and the parity_err output.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int INSTR_W = IMEM_INSTR_W,
  parameter int DEPTH   = 1 << ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic               ready,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  address,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic               addr_err
`ifdef IMEM_PARITY_EN
  ,
  output logic               parity_err
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = INSTR_W + 1;
`else
  localparam int MEM_W = INSTR_W;
`endif
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic               we;
  logic [IDX_W-1:0]   waddr;
  logic [INSTR_W-1:0] wdata;
  logic [MEM_W-1:0]   wword;
  logic [MEM_W-1:0]   rd_word;
  logic               in_range;

  logic [MEM_W-1:0]   mem_q [DEPTH];

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               aerr_q, aerr_d;
`ifdef IMEM_PARITY_EN
  logic               perr_q, perr_d;
`endif

  imem_load_ctrl #(
    .PTR_W  (IDX_W),
    .INSTR_W(INSTR_W),
    .DEPTH  (DEPTH)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .load_valid_i(load_valid),
    .load_data_i (load_data),
    .load_last_i (load_last),
    .load_ready_o(load_ready),
    .ready_o     (ready),
    .we_o        (we),
    .waddr_o     (waddr),
    .wdata_o     (wdata)
  );

  // Stored word: data, plus its parity bit in the MSB when enabled.
  always_comb begin
`ifdef IMEM_PARITY_EN
    wword = {imem_parity(IMEM_PARITY_MAX_W'(wdata)), wdata};
`else
    wword = wdata;
`endif
  end

  // Storage array; only the load controller writes it (clear and load).
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wword;
    end
  end

  // Read path: out-of-range reads return zero and flag addr_err.
  always_comb begin
    in_range = ({1'b0, address} < DEPTH_LIM);
    rd_word  = mem_q[address[IDX_W-1:0]];
    instr_d  = instr_q;
    valid_d  = 1'b0;
    aerr_d   = 1'b0;
`ifdef IMEM_PARITY_EN
    perr_d   = 1'b0;
`endif
    if (ready && rd_en) begin
      valid_d = 1'b1;
      if (in_range) begin
        instr_d = rd_word[INSTR_W-1:0];
`ifdef IMEM_PARITY_EN
        perr_d  = imem_parity(IMEM_PARITY_MAX_W'(rd_word[INSTR_W-1:0])) != rd_word[INSTR_W];
`endif
      end else begin
        instr_d = '0;
        aerr_d  = 1'b1;
      end
    end
  end

  // Registered read outputs; instruction holds when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      aerr_q  <= 1'b0;
`ifdef IMEM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      aerr_q  <= aerr_d;
`ifdef IMEM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    instruction = instr_q;
    instr_valid = valid_q;
    addr_err    = aerr_q;
`ifdef IMEM_PARITY_EN
    parity_err  = perr_q;
`endif
  end

endmodule
